// File: rtl/vga_note_writer.sv
// Avalon-MM write initiator for the note-display peripheral: note FIFO, score and clear sweeps.
// Optional macro VGA_NOTE_WRITER_VBLANK_EN adds a vblank input gating new transfers.
module vga_note_writer #(
    parameter int          FIFO_DEPTH = 16,
    parameter int          NUM_SLOTS  = 64,
    parameter logic [15:0] NOTE_ADDR  = 16'h6,
    parameter logic [15:0] SCORE_ADDR = 16'h4,
    localparam int         AW         = $clog2(FIFO_DEPTH),
    localparam int         LW         = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
`ifdef VGA_NOTE_WRITER_VBLANK_EN
    input  logic          vblank,
`endif
    input  logic          note_valid,
    output logic          note_ready,
    input  logic [5:0]    note_index,
    input  logic [5:0]    note_id,
    input  logic [9:0]    note_x,
    input  logic [9:0]    note_y,
    input  logic          score_valid,
    input  logic [15:0]   score,
    input  logic [15:0]   combo,
    input  logic          clear_req,
    output logic          busy,
    output logic [LW-1:0] fifo_level,
    output logic [15:0]   avm_address,
    output logic [31:0]   avm_writedata,
    output logic          avm_write,
    output logic          avm_chipselect,
    input  logic          avm_waitrequest
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        SWEEP
    } state_t;

    state_t state_q, state_d;

    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] count_q;
    logic          full, empty;
    logic          push, pop, pop_req;

    logic [15:0] score_q, combo_q;
    logic        score_pend_q, score_done;
    logic        clear_pend_q, clear_accept, sweep_done;

    logic [15:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        write_q, write_d;
    logic        kind_q, kind_d;
    logic [5:0]  slot_q, slot_d;
    logic        start_ok;

`ifdef VGA_NOTE_WRITER_VBLANK_EN
    assign start_ok = vblank;
`else
    assign start_ok = 1'b1;
`endif

    assign full         = (count_q == LW'(FIFO_DEPTH));
    assign empty        = (count_q == '0);
    assign note_ready   = reset_n && !full && !clear_pend_q && !clear_req;
    assign push         = note_valid && note_ready;
    assign pop          = pop_req && !empty;
    // A clear that arrives during an active sweep is dropped entirely.
    assign clear_accept = clear_req && !clear_pend_q;

    assign busy           = clear_pend_q;
    assign fifo_level     = count_q;
    assign avm_address    = addr_q;
    assign avm_writedata  = data_q;
    assign avm_write      = write_q;
    assign avm_chipselect = write_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {note_index, note_id, note_y, note_x};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_accept) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            score_q      <= '0;
            combo_q      <= '0;
            score_pend_q <= 1'b0;
            clear_pend_q <= 1'b0;
        end else begin
            // A fresh pulse wins over completion so no update is lost.
            if (score_valid) begin
                score_q      <= score;
                combo_q      <= combo;
                score_pend_q <= 1'b1;
            end else if (score_done) begin
                score_pend_q <= 1'b0;
            end
            if (clear_accept) begin
                clear_pend_q <= 1'b1;
            end else if (sweep_done) begin
                clear_pend_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        write_d    = write_q;
        kind_d     = kind_q;
        slot_d     = slot_q;
        pop_req    = 1'b0;
        score_done = 1'b0;
        sweep_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    if (clear_pend_q || clear_accept) begin
                        state_d = SWEEP;
                        addr_d  = NOTE_ADDR;
                        data_d  = '0;
                        write_d = 1'b1;
                        slot_d  = '0;
                    end else if (score_pend_q) begin
                        state_d = XFER;
                        addr_d  = SCORE_ADDR;
                        data_d  = {combo_q, score_q};
                        write_d = 1'b1;
                        kind_d  = 1'b1;
                    end else if (!empty) begin
                        state_d = XFER;
                        addr_d  = NOTE_ADDR;
                        data_d  = mem_q[rd_ptr_q];
                        write_d = 1'b1;
                        kind_d  = 1'b0;
                    end
                end
            end
            XFER: begin
                if (!avm_waitrequest) begin
                    write_d    = 1'b0;
                    state_d    = IDLE;
                    pop_req    = !kind_q;
                    score_done = kind_q;
                end
            end
            SWEEP: begin
                if (write_q) begin
                    if (!avm_waitrequest) begin
                        write_d = 1'b0;
                        if (slot_q == 6'(NUM_SLOTS - 1)) begin
                            sweep_done = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            slot_d = slot_q + 1'b1;
                        end
                    end
                end else if (start_ok) begin
                    write_d = 1'b1;
                    data_d  = {slot_q, 26'd0};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
            kind_q  <= 1'b0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            write_q <= write_d;
            kind_q  <= kind_d;
            slot_q  <= slot_d;
        end
    end

endmodule

// File: tb/tb_vga_note_writer.sv
// Scoreboard bench for vga_note_writer: stimulus queues expected writes, a monitor checks them.
module tb_vga_note_writer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        note_valid, note_ready;
    logic [5:0]  note_index, note_id;
    logic [9:0]  note_x, note_y;
    logic        score_valid;
    logic [15:0] score, combo;
    logic        clear_req, busy;
    logic [4:0]  fifo_level;
    logic [15:0] avm_address;
    logic [31:0] avm_writedata;
    logic        avm_write, avm_chipselect, avm_waitrequest;

    vga_note_writer dut (
        .clk(clk), .reset_n(reset_n),
        .note_valid(note_valid), .note_ready(note_ready),
        .note_index(note_index), .note_id(note_id),
        .note_x(note_x), .note_y(note_y),
        .score_valid(score_valid), .score(score), .combo(combo),
        .clear_req(clear_req), .busy(busy), .fifo_level(fifo_level),
        .avm_address(avm_address), .avm_writedata(avm_writedata),
        .avm_write(avm_write), .avm_chipselect(avm_chipselect),
        .avm_waitrequest(avm_waitrequest)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    bit rand_wr = 1'b0;
    logic [47:0] exp_q [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] ex);
        total++;
        if (act !== ex) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, ex);
        end
    endtask

    function automatic logic [47:0] note_exp(input int i, input int id, input int x, input int y);
        int w;
        w = i * 67108864 + id * 1048576 + y * 1024 + x;
        return {16'h6, 32'(w)};
    endfunction

    // Monitor: a write completes at the next rising edge if write=1 and waitrequest=0 now.
    logic        pw, pwr, pdone;
    logic [15:0] pa;
    logic [31:0] pd;
    logic [47:0] e;
    always @(negedge clk) begin
        if (!reset_n) begin
            pw = 1'b0;
            pdone = 1'b0;
        end else begin
            if (avm_write) chk("chipselect", avm_chipselect, 1);
            if (pdone) chk("gap_after_beat", avm_write, 0);
            if (pw && pwr) begin
                chk("hold_write", avm_write, 1);
                chk("hold_addr", avm_address, pa);
                chk("hold_data", avm_writedata, pd);
            end
            pdone = 1'b0;
            if (avm_write && !avm_waitrequest) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got %0h/%0h want none", avm_address, avm_writedata);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", avm_address, e[47:32]);
                    chk("wr_data", avm_writedata, e[31:0]);
                end
                done_cnt++;
                pdone = 1'b1;
            end
            pw = avm_write;
            pwr = avm_waitrequest;
            pa = avm_address;
            pd = avm_writedata;
        end
    end

    always @(posedge clk) begin
        if (rand_wr) begin
            #1;
            avm_waitrequest = ($urandom_range(0, 2) == 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rand(input bit on);
        rand_wr = on;
        @(posedge clk);
        #2;
        if (!on) avm_waitrequest = 1'b0;
        step();
    endtask

    task automatic push_note(input int i, input int id, input int x, input int y, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        note_index = 6'(i);
        note_id = 6'(id);
        note_x = 10'(x);
        note_y = 10'(y);
        note_valid = 1'b1;
        while (!ok && n < 300) begin
            #1;
            if (note_ready) ok = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        note_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL push_timeout: got ready=0 want ready=1");
        end
    endtask

    task automatic push_exp(input int i, input int id, input int x, input int y);
        bit ok;
        push_note(i, id, x, y, ok);
        if (ok) exp_q.push_back(note_exp(i, id, x, y));
    endtask

    task automatic pulse_score(input logic [15:0] s, input logic [15:0] c);
        score = s;
        combo = c;
        score_valid = 1'b1;
        step();
        score_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) step();
    endtask

    task automatic queue_sweep();
        for (int k = 0; k < 64; k++) begin
            exp_q.push_back({16'h6, 32'(k * 67108864)});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [47:0] held [3];
        int base, n;
        reset_n = 1'b0;
        note_valid = 0; note_index = 0; note_id = 0; note_x = 0; note_y = 0;
        score_valid = 0; score = 0; combo = 0; clear_req = 0;
        avm_waitrequest = 1'b0;
        #12;
        chk("rst_write", avm_write, 0);
        chk("rst_cs", avm_chipselect, 0);
        chk("rst_addr", avm_address, 0);
        chk("rst_data", avm_writedata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", note_ready, 0);
        step();
        reset_n = 1'b1;
        step();
        chk("ready_after_rst", note_ready, 1);

        // single note, minimum latency
        push_exp(5, 10, 256, 100);
        chk("level_after_push", fifo_level, 1);
        step();
        chk("latency_write", avm_write, 1);
        drain();
        chk("level_drained", fifo_level, 0);

        // stalled transfer
        avm_waitrequest = 1'b1;
        push_exp(33, 7, 1023, 511);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("stall_level", fifo_level, 1);
        end
        avm_waitrequest = 1'b0;
        step();
        chk("stall_pop", fifo_level, 0);
        drain();

        // score overtakes queued notes, last pulse wins
        avm_waitrequest = 1'b1;
        push_exp(1, 2, 3, 4);
        for (int j = 0; j < 3; j++) begin
            push_note(j + 10, j + 20, j * 40, j * 50, ok);
            held[j] = note_exp(j + 10, j + 20, j * 40, j * 50);
        end
        pulse_score(16'h1234, 16'h0056);
        pulse_score(16'h2000, 16'h0056);
        exp_q.push_back({16'h4, 32'(16'h0056 * 65536 + 16'h2000)});
        for (int j = 0; j < 3; j++) exp_q.push_back(held[j]);
        chk("score_level", fifo_level, 4);
        avm_waitrequest = 1'b0;
        drain();

        // fill to full
        avm_waitrequest = 1'b1;
        for (int j = 0; j < 16; j++) push_exp(j, 63 - j, j * 60, 1000 - j);
        chk("full_level", fifo_level, 16);
        chk("full_ready", note_ready, 0);
        avm_waitrequest = 1'b0;
        step();
        avm_waitrequest = 1'b1;
        chk("one_out_level", fifo_level, 15);
        chk("one_out_ready", note_ready, 1);
        avm_waitrequest = 1'b0;
        drain();

        // clear with queued notes; repeat clear ignored, score deferred
        avm_waitrequest = 1'b1;
        push_exp(9, 9, 9, 9);
        for (int j = 0; j < 3; j++) push_note(j, 1, 2, 3, ok);
        chk("pre_clear_level", fifo_level, 4);
        clear_req = 1'b1;
        #1;
        chk("ready_during_clear", note_ready, 0);
        step();
        clear_req = 1'b0;
        chk("clear_flush", fifo_level, 0);
        chk("clear_busy", busy, 1);
        chk("busy_ready", note_ready, 0);
        queue_sweep();
        avm_waitrequest = 1'b0;
        repeat (10) step();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        pulse_score(16'hBEEF, 16'h0102);
        exp_q.push_back({16'h4, 32'h0102BEEF});
        n = 0;
        while (busy && n < 1000) begin
            step();
            n++;
        end
        chk("busy_drop", busy, 0);
        chk("post_sweep_ready", note_ready, 1);
        drain();

        // randomized notes with random stalls
        set_rand(1);
        for (int j = 0; j < 60; j++) begin
            if ($urandom_range(0, 1) == 1) begin
                push_exp(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                         int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            end else begin
                step();
            end
        end
        drain();
        set_rand(0);
        drain();
        chk("rand_level", fifo_level, 0);

        // reset in the middle of a sweep
        base = done_cnt;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        queue_sweep();
        n = 0;
        while (done_cnt < base + 20 && n < 500) begin
            step();
            n++;
        end
        chk("sweep_progress", 32'(done_cnt - base), 20);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_write", avm_write, 0);
        chk("async_cs", avm_chipselect, 0);
        chk("async_addr", avm_address, 0);
        chk("async_data", avm_writedata, 0);
        chk("async_busy", busy, 0);
        chk("async_level", fifo_level, 0);
        exp_q.delete();
        step();
        reset_n = 1'b1;
        repeat (20) step();
        chk("idle_write", avm_write, 0);
        chk("idle_busy", busy, 0);
        chk("idle_ready", note_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_note_writer.md
Name: vga_note_writer

Overview:
Avalon-MM write initiator that drives the note-display peripheral's register map (score/combo at address 4, gamedata at 5, note packets at 6). Game logic pushes note updates through a valid/ready port into an internal FIFO. Score updates and full-table clears go through separate request ports. The block serialises everything into single-beat Avalon writes, honouring waitrequest. It sits between game/HPS-side logic and the display peripheral on the same clock.

Parameters:
FIFO_DEPTH, 16, note FIFO entries; power of two, 2..64
NUM_SLOTS, 64, note slot indices swept by a clear (1..64)
NOTE_ADDR, 16'h6, Avalon address for note packets
SCORE_ADDR, 16'h4, Avalon address for score/combo word

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
note_valid  in  1  note push request
note_ready  out  1  note push accepted when valid&&ready
note_index  in  6  slot index 0-63
note_id  in  6  sprite id; 0 = empty slot
note_x  in  10  x coordinate
note_y  in  10  y coordinate
score_valid  in  1  one-cycle pulse: latch score/combo
score  in  16  score value
combo  in  16  combo value
clear_req  in  1  one-cycle pulse: blank all slots
busy  out  1  high while a clear sweep is pending or running
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
avm_address  out  16  Avalon address
avm_writedata  out  32  Avalon write data
avm_write  out  1  Avalon write strobe
avm_chipselect  out  1  Avalon chipselect; equals avm_write
avm_waitrequest  in  1  target stall

Behaviour:
- Reset values (async, reset_n low): avm_write=0, avm_chipselect=0, avm_address=0, avm_writedata=0, busy=0, FIFO empty, fifo_level=0, score pending=0, clear pending=0, FSM=IDLE.
- note_ready = !full && !busy && !clear_req; it is combinational and held low during reset.
- Note packing: writedata = {index[5:0], id[5:0], y[9:0], x[9:0]}. Bits 31:26 carry the index, 25:20 the id, 19:10 y, 9:0 x. Coordinates are passed through unclamped.
- Score packing: writedata = {combo, score}.
- score_valid latches the values and sets score pending. A new pulse before issue overwrites the held values (last wins).
- clear_req sets clear pending and busy, and flushes the FIFO on the same edge. A push in that same cycle is rejected.
- FSM states:
  - IDLE: arbitrates in priority order CLEAR > SCORE > NOTE (FIFO non-empty). It loads address and data, asserts avm_write and avm_chipselect on the next edge, then goes to XFER or SWEEP.
  - XFER: holds address, data and write stable while avm_waitrequest=1. A transfer completes on the first edge with avm_write=1 and avm_waitrequest=0. On completion, write deasserts, the FIFO pops (note) or the score-pending flag clears (score), and the FSM returns to IDLE.
  - SWEEP: issues NUM_SLOTS writes to NOTE_ADDR, slot k = 0..NUM_SLOTS-1, each with writedata = {k, 26'd0}. Each write completes under the same waitrequest rule. Write is deasserted for one cycle between beats. After slot NUM_SLOTS-1 completes, clear pending and busy drop and the FSM returns to IDLE.
- Throughput: at most one write per 2 cycles. Minimum latency: a push accepted at edge E0 gives avm_write=1 after edge E1.
- A FIFO push and pop in the same cycle leaves the level unchanged. Push when full is impossible (ready low). Pop when empty never occurs.
- score_valid during SWEEP is latched and issued after the sweep. clear_req during SWEEP is ignored (already busy).
- An XFER in progress is never aborted by new requests.
- Reset mid-transfer drops avm_write immediately. The target is reset in the same domain.

Optional Feature:
VGA_NOTE_WRITER_VBLANK_EN: adds input port vblank (1 bit, vertical blanking active high).
- With the macro: IDLE starts a new transfer or sweep beat only while vblank=1. A transfer already in XFER completes regardless of vblank.
- Without it: no port, and transfers start whenever a request is pending.

Test Plan:
- Push index=5, id=10, x=256, y=100 with waitrequest=0 -> exactly one write, address 0x6, writedata 0x14A19100, avm_write high for 1 cycle, fifo_level back to 0.
- Hold waitrequest=1 for 5 cycles during a note write -> address/data/write stable for all 6 cycles, FIFO pops once only when waitrequest drops.
- score_valid score=0x1234, combo=0x0056, then score_valid score=0x2000 before issue, with FIFO holding 3 notes -> a single score write 0x00562000 at address 0x4 issued before any note write.
- Fill FIFO to 16 -> note_ready=0 and fifo_level=16; one completed write -> note_ready=1 and level 15.
- clear_req with 4 notes queued -> FIFO flushed (level 0), busy high, 64 writes with writedata 0x00000000, 0x04000000 ... 0xFC000000, then busy=0 and note_ready=1.
- Assert reset_n=0 mid-SWEEP at slot 20 -> all outputs return to reset values asynchronously, with no further writes after release until a new request.
